// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ALU ADD code, control-FSM state encoding and strobe bundle.
// The PAUSE state exists only when CU_SINGLE_STEP_EN is defined.
package cpu_pkg;

  localparam int OPW  = 5;
  localparam int WORD = 32;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPW-1:0] OP_AND  = 5'b01010;
  localparam logic [OPW-1:0] OP_OR   = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [OPW-1:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    T0     = 4'd0,
    T1     = 4'd1,
    T2     = 4'd2,
    T3     = 4'd3,
    T4     = 4'd4,
    T5     = 4'd5,
    T6     = 4'd6,
    T7     = 4'd7,
    S_HALT = 4'd8
`ifdef CU_SINGLE_STEP_EN
    ,
    S_PAUSE = 4'd9
`endif
  } state_e;

  typedef enum logic [3:0] {
    C_ALU3, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_RSVD
  } op_class_e;

  typedef struct packed {
    logic           pc_out;
    logic           zlow_out;
    logic           zhigh_out;
    logic           mdr_out;
    logic           c_out;
    logic           in_port_out;
    logic           lo_out;
    logic           hi_out;
    logic           mar_in;
    logic           z_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           inc_pc;
    logic           hi_in;
    logic           lo_in;
    logic           con_in;
    logic           out_port_in;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           r_in;
    logic           r_out;
    logic           ba_out;
    logic           read;
    logic           write;
    logic [OPW-1:0] opcode;
    logic           illegal;
  } ctrl_t;

  function automatic op_class_e classify(input logic [OPW-1:0] op);
    case (op) inside
      OP_LD:             return C_LD;
      OP_LDI:            return C_LDI;
      OP_ST:             return C_ST;
      [OP_ADD:OP_OR]:    return C_ALU3;
      [OP_ADDI:OP_ORI]:  return C_IMM;
      OP_MUL, OP_DIV:    return C_MULDIV;
      OP_NEG, OP_NOT:    return C_UNARY;
      OP_BR:             return C_BR;
      OP_JR:             return C_JR;
      OP_IN:             return C_IN;
      OP_OUT:            return C_OUT;
      OP_MFHI:           return C_MFHI;
      OP_MFLO:           return C_MFLO;
      OP_NOP:            return C_NOP;
      OP_HALT:           return C_HALT;
      default:           return C_RSVD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control FSM: fetch in T0-T2, opcode-driven execute in T3-T7, sticky HALT.
// Define CU_SINGLE_STEP_EN to add a step input and a PAUSE state between instructions.
module control_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [WORD-1:0] ir,
  input  logic            con_ff,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            Cout,
  output logic            In_Portout,
  output logic            LOout,
  output logic            HIout,
  output logic            MARIn,
  output logic            ZIn,
  output logic            PCIn,
  output logic            MDRIn,
  output logic            IRIn,
  output logic            YIn,
  output logic            IncPC,
  output logic            HiIn,
  output logic            LoIn,
  output logic            CONIn,
  output logic            OutPortIn,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            read,
  output logic            write,
  output logic [OPW-1:0]  opcode,
  output logic            run,
  output logic            illegal
);

  state_e         state_q, state_d;
  ctrl_t          ctrl, ctrl_gated;
  logic [OPW-1:0] op;
  op_class_e      cls;
  logic [2:0]     step_idx;
  logic           last;
  logic           unused_ir;

  assign op        = ir[WORD-1:WORD-OPW];
  assign cls       = classify(op);
  assign step_idx  = 3'(state_q - T3);
  assign unused_ir = ^ir[WORD-OPW-1:0];

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  localparam state_e DONE_STATE = S_PAUSE;

  // A step already high during the final execute step must drop and rise again.
  assign step_rise = step & ~step_q;

  always_ff @(posedge clk) begin
    if (clr) step_q <= 1'b0;
    else     step_q <= step;
  end
`else
  localparam state_e DONE_STATE = T0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (clr) state_q <= T0;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    ctrl    = '0;
    last    = 1'b0;
    state_d = state_q;
    case (state_q)
      T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
        state_d = T1;
      end
      T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        state_d = T2;
      end
      T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
        state_d = T3;
      end
      T3, T4, T5, T6, T7: begin
        unique case (cls)
          C_ALU3, C_IMM: begin
            case (step_idx)
              3'd0: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd1: begin
                if (cls == C_ALU3) begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; end
                else               ctrl.c_out = 1'b1;
                ctrl.z_in = 1'b1; ctrl.opcode = op;
              end
              default: begin
                ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1;
              end
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (step_idx)
              3'd0: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd1: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.opcode = ALU_ADD; end
              3'd2: begin
                ctrl.zlow_out = 1'b1;
                if (cls == C_LDI) begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
                else              ctrl.mar_in = 1'b1;
              end
              3'd3: begin
                ctrl.mdr_in = 1'b1;
                if (cls == C_LD) ctrl.read = 1'b1;
                else begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; end
              end
              default: begin
                if (cls == C_LD) begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                else             ctrl.write = 1'b1;
                last = 1'b1;
              end
            endcase
          end
          C_MULDIV: begin
            case (step_idx)
              3'd0: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd1: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.opcode = op; end
              3'd2: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
              default: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; last = 1'b1; end
            endcase
          end
          C_UNARY: begin
            case (step_idx)
              3'd0: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; ctrl.opcode = op; end
              default: begin
                ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1;
              end
            endcase
          end
          C_BR: begin
            case (step_idx)
              3'd0: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              3'd1: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd2: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.opcode = ALU_ADD; end
              default: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff; last = 1'b1; end
            endcase
          end
          C_JR:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; last = 1'b1; end
          C_IN:   begin ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
          C_OUT:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_in = 1'b1; last = 1'b1; end
          C_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
          C_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; last = 1'b1; end
          C_HALT: last = 1'b0;
          C_RSVD: begin ctrl.illegal = 1'b1; last = 1'b1; end
          default: last = 1'b1;
        endcase
        if (cls == C_HALT) state_d = S_HALT;
        else if (last)     state_d = DONE_STATE;
        else               state_d = state_e'(state_q + 4'd1);
      end
      S_HALT: state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE: if (step_rise) state_d = T0;
`endif
      default: state_d = T0;
    endcase
  end

  // clr silences every strobe in the same cycle, independent of the registered state.
  assign ctrl_gated = clr ? '0 : ctrl;

`ifdef CU_SINGLE_STEP_EN
  assign run = ~clr & (state_q != S_HALT) & (state_q != S_PAUSE);
`else
  assign run = ~clr & (state_q != S_HALT);
`endif

  assign PCout      = ctrl_gated.pc_out;
  assign Zlowout    = ctrl_gated.zlow_out;
  assign Zhighout   = ctrl_gated.zhigh_out;
  assign MDRout     = ctrl_gated.mdr_out;
  assign Cout       = ctrl_gated.c_out;
  assign In_Portout = ctrl_gated.in_port_out;
  assign LOout      = ctrl_gated.lo_out;
  assign HIout      = ctrl_gated.hi_out;
  assign MARIn      = ctrl_gated.mar_in;
  assign ZIn        = ctrl_gated.z_in;
  assign PCIn       = ctrl_gated.pc_in;
  assign MDRIn      = ctrl_gated.mdr_in;
  assign IRIn       = ctrl_gated.ir_in;
  assign YIn        = ctrl_gated.y_in;
  assign IncPC      = ctrl_gated.inc_pc;
  assign HiIn       = ctrl_gated.hi_in;
  assign LoIn       = ctrl_gated.lo_in;
  assign CONIn      = ctrl_gated.con_in;
  assign OutPortIn  = ctrl_gated.out_port_in;
  assign Gra        = ctrl_gated.gra;
  assign Grb        = ctrl_gated.grb;
  assign Grc        = ctrl_gated.grc;
  assign Rin        = ctrl_gated.r_in;
  assign Rout       = ctrl_gated.r_out;
  assign BAout      = ctrl_gated.ba_out;
  assign read       = ctrl_gated.read;
  assign write      = ctrl_gated.write;
  assign opcode     = ctrl_gated.opcode;
  assign illegal    = ctrl_gated.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues one expected strobe vector per cycle,
// a negedge monitor pops and compares it against the observed outputs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
  logic MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CONIn, OutPortIn;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, run, illegal;
  logic [4:0] opcode;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr),
`ifdef CU_SINGLE_STEP_EN
    .step(1'b0),
`endif
    .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .In_Portout(In_Portout), .LOout(LOout), .HIout(HIout),
    .MARIn(MARIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
    .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CONIn(CONIn), .OutPortIn(OutPortIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .read(read), .write(write), .opcode(opcode), .run(run), .illegal(illegal)
  );

  localparam logic [26:0] PCO  = 27'd1 << 0,  ZLO  = 27'd1 << 1,  ZHI  = 27'd1 << 2;
  localparam logic [26:0] MDRO = 27'd1 << 3,  CO   = 27'd1 << 4,  INPO = 27'd1 << 5;
  localparam logic [26:0] LOO  = 27'd1 << 6,  HIO  = 27'd1 << 7,  MARI = 27'd1 << 8;
  localparam logic [26:0] ZI   = 27'd1 << 9,  PCI  = 27'd1 << 10, MDRI = 27'd1 << 11;
  localparam logic [26:0] IRI  = 27'd1 << 12, YI   = 27'd1 << 13, INC  = 27'd1 << 14;
  localparam logic [26:0] HII  = 27'd1 << 15, LOI  = 27'd1 << 16, CONI = 27'd1 << 17;
  localparam logic [26:0] OPI  = 27'd1 << 18, GRA  = 27'd1 << 19, GRB  = 27'd1 << 20;
  localparam logic [26:0] GRC  = 27'd1 << 21, RIN  = 27'd1 << 22, ROUT = 27'd1 << 23;
  localparam logic [26:0] BAO  = 27'd1 << 24, RD   = 27'd1 << 25, WR   = 27'd1 << 26;
  localparam logic [26:0] NONE = 27'd0;

  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic logic [33:0] ex(input logic [26:0] s, input logic [4:0] op,
                                     input logic ill, input logic rn);
    return {ill, rn, op, s};
  endfunction

  function automatic logic [33:0] r1(input logic [26:0] s);
    return ex(s, 5'd0, 1'b0, 1'b1);
  endfunction

  task automatic check(input string tag, input logic [33:0] act, input logic [33:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [33:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] i, input string nm);
    ir = i;
    cyc({nm, " T0"}, r1(PCO | MARI | INC | ZI));
    cyc({nm, " T1"}, r1(ZLO | PCI | RD | MDRI));
    cyc({nm, " T2"}, r1(MDRO | IRI));
  endtask

  // Monitor: one popped expectation per cycle, plus the bus-source and read/write invariants.
  initial begin
    logic [33:0] obs;
    exp_t        e;
    forever begin
      @(negedge clk);
      obs = {illegal, run, opcode, write, read, BAout, Rout, Rin, Grc, Grb, Gra,
             OutPortIn, CONIn, LoIn, HiIn, IncPC, YIn, IRIn, MDRIn, PCIn, ZIn, MARIn,
             HIout, LOout, In_Portout, Cout, MDRout, Zhighout, Zlowout, PCout};
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, obs, e.v);
        check({e.tag, " invariant"}, {33'd0, $onehot0(obs[7:0]) && !(read && write)}, 34'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic [31:0] i;
    logic [33:0] t3;
  } single_t;

  single_t singles[8];

  initial begin
    singles[0] = '{"jr",   32'hA000_0000, r1(GRA | ROUT | PCI)};
    singles[1] = '{"in",   32'hB000_0000, r1(INPO | GRA | RIN)};
    singles[2] = '{"out",  32'hB800_0000, r1(GRA | ROUT | OPI)};
    singles[3] = '{"mfhi", 32'hC000_0000, r1(HIO | GRA | RIN)};
    singles[4] = '{"mflo", 32'hC800_0000, r1(LOO | GRA | RIN)};
    singles[5] = '{"nop",  32'hD000_0000, r1(NONE)};
    singles[6] = '{"rsvd10101", 32'hA800_0000, ex(NONE, 5'd0, 1'b1, 1'b1)};
    singles[7] = '{"rsvd11110", 32'hF000_0000, ex(NONE, 5'd0, 1'b1, 1'b1)};

    clr = 1'b1; ir = 32'h0; con_ff = 1'b0;
    @(posedge clk); #1;
    repeat (3) cyc("reset", ex(NONE, 5'd0, 1'b0, 1'b0));
    clr = 1'b0;

    fetch(32'h1891_0000, "add");
    cyc("add T3", r1(GRB | ROUT | YI));
    cyc("add T4", ex(GRC | ROUT | ZI, 5'b00011, 1'b0, 1'b1));
    cyc("add T5", r1(ZLO | GRA | RIN));

    fetch(32'h5000_0000, "and");
    cyc("and T3", r1(GRB | ROUT | YI));
    cyc("and T4", ex(GRC | ROUT | ZI, 5'b01010, 1'b0, 1'b1));
    cyc("and T5", r1(ZLO | GRA | RIN));

    fetch(32'h6000_0000, "addi");
    cyc("addi T3", r1(GRB | ROUT | YI));
    cyc("addi T4", ex(CO | ZI, 5'b01100, 1'b0, 1'b1));
    cyc("addi T5", r1(ZLO | GRA | RIN));

    fetch(32'h0080_0055, "ld");
    cyc("ld T3", r1(GRB | BAO | YI));
    cyc("ld T4", ex(CO | ZI, 5'b00011, 1'b0, 1'b1));
    cyc("ld T5", r1(ZLO | MARI));
    cyc("ld T6", r1(RD | MDRI));
    cyc("ld T7", r1(MDRO | GRA | RIN));

    fetch(32'h0800_0000, "ldi");
    cyc("ldi T3", r1(GRB | BAO | YI));
    cyc("ldi T4", ex(CO | ZI, 5'b00011, 1'b0, 1'b1));
    cyc("ldi T5", r1(ZLO | GRA | RIN));

    fetch(32'h1000_0000, "st");
    cyc("st T3", r1(GRB | BAO | YI));
    cyc("st T4", ex(CO | ZI, 5'b00011, 1'b0, 1'b1));
    cyc("st T5", r1(ZLO | MARI));
    cyc("st T6", r1(GRA | ROUT | MDRI));
    cyc("st T7", r1(WR));

    fetch(32'h7800_0000, "mul");
    cyc("mul T3", r1(GRA | ROUT | YI));
    cyc("mul T4", ex(GRB | ROUT | ZI, 5'b01111, 1'b0, 1'b1));
    cyc("mul T5", r1(ZLO | LOI));
    cyc("mul T6", r1(ZHI | HII));

    fetch(32'h8800_0000, "neg");
    cyc("neg T3", ex(GRB | ROUT | ZI, 5'b10001, 1'b0, 1'b1));
    cyc("neg T4", r1(ZLO | GRA | RIN));

    for (int b = 0; b < 2; b++) begin
      con_ff = 1'(b);
      fetch(32'h9800_0000, "br");
      cyc("br T3", r1(GRA | ROUT | CONI));
      cyc("br T4", r1(PCO | YI));
      cyc("br T5", ex(CO | ZI, 5'b00011, 1'b0, 1'b1));
      cyc(b == 0 ? "br T6 con0" : "br T6 con1", r1(b == 0 ? ZLO : (ZLO | PCI)));
    end
    con_ff = 1'b0;

    foreach (singles[k]) begin
      fetch(singles[k].i, singles[k].nm);
      cyc({singles[k].nm, " T3"}, singles[k].t3);
    end

    fetch(32'h0080_0055, "ld-abort");
    cyc("ld-abort T3", r1(GRB | BAO | YI));
    cyc("ld-abort T4", ex(CO | ZI, 5'b00011, 1'b0, 1'b1));
    clr = 1'b1;
    cyc("ld-abort clr", ex(NONE, 5'd0, 1'b0, 1'b0));
    clr = 1'b0;
    fetch(32'hD000_0000, "after-abort");
    cyc("after-abort T3", r1(NONE));

    fetch(32'hD800_0000, "halt");
    cyc("halt T3", r1(NONE));
    repeat (20) cyc("halted", ex(NONE, 5'd0, 1'b0, 1'b0));
    clr = 1'b1;
    cyc("halt clr", ex(NONE, 5'd0, 1'b0, 1'b0));
    clr = 1'b0;
    cyc("post-halt T0", r1(PCO | MARI | INC | ZI));

    check("scoreboard drained", 34'(sb.size()), 34'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
